// File: rtl/therm_pkg.sv
// ============================================================================
//  Module  : therm_pkg
//  Brief   : Shared constants, state encoding and helpers for the thermometer
//            sequencer. THERM_SEQ_CHECKSUM_EN selects the 4-byte frame.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package therm_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef THERM_SEQ_CHECKSUM_EN
    localparam int FRAME_LEN = 4;
`else
    localparam int FRAME_LEN = 3;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_GATE    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_CAPTURE = 3'd4,
        ST_SEND    = 3'd5,
        ST_WAIT    = 3'd6
    } therm_seq_state_t;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/therm_seq_ctrl_if.sv
// ============================================================================
//  Module  : therm_seq_ctrl_if
//  Brief   : Byte valid/ready bus from the sequencer to the UART transmitter.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

interface therm_seq_ctrl_if ();
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

`default_nettype wire

// File: rtl/therm_frame_tx.sv
// ============================================================================
//  Module  : therm_frame_tx
//  Brief   : Loads a sample frame on a one-cycle pulse and streams it out over
//            valid/ready. THERM_SEQ_CHECKSUM_EN appends a checksum byte.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module therm_frame_tx
    import therm_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        load,
    input  wire logic [15:0] cnt,
    therm_seq_ctrl_if.master tx,
    output logic             done
);

    logic [7:0] r_msb;
    logic [7:0] r_lsb;
    logic [1:0] r_idx;
    logic [7:0] r_data;
    logic       r_valid;
    logic       r_done;
`ifdef THERM_SEQ_CHECKSUM_EN
    logic [7:0] r_sum;
`endif

    logic       w_xfer;
    logic       w_last;
    logic [7:0] w_next_byte;

    assign w_xfer = r_valid & tx.tx_ready;
    assign w_last = (r_idx == 2'(FRAME_LEN - 1));

    // Byte that follows the one currently on the bus.
    always_comb begin
        w_next_byte = r_lsb;
        case (r_idx)
            2'd0:    w_next_byte = r_msb;
            2'd1:    w_next_byte = r_lsb;
`ifdef THERM_SEQ_CHECKSUM_EN
            2'd2:    w_next_byte = r_sum;
`endif
            default: w_next_byte = r_lsb;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_msb   <= 8'd0;
            r_lsb   <= 8'd0;
            r_idx   <= 2'd0;
            r_data  <= 8'd0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
`ifdef THERM_SEQ_CHECKSUM_EN
            r_sum   <= 8'd0;
`endif
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_msb   <= cnt[15:8];
                r_lsb   <= cnt[7:0];
`ifdef THERM_SEQ_CHECKSUM_EN
                r_sum   <= SYNC_BYTE + cnt[15:8] + cnt[7:0];
`endif
                r_idx   <= 2'd0;
                r_data  <= SYNC_BYTE;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                if (w_last) begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_idx  <= r_idx + 2'd1;
                    r_data <= w_next_byte;
                end
            end
        end
    end

    assign tx.tx_data  = r_data;
    assign tx.tx_valid = r_valid;
    assign done        = r_done;

endmodule

`default_nettype wire

// File: rtl/therm_seq_ctrl.sv
// ============================================================================
//  Module  : therm_seq_ctrl
//  Brief   : Ring-oscillator thermometer sequencer: settle, gate, hold,
//            capture, then frame the count to the UART (THERM_SEQ_CHECKSUM_EN
//            adds a checksum byte).
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module therm_seq_ctrl
    import therm_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 64,
    parameter int GATE_CYCLES     = 10000,
    parameter int HOLD_CYCLES     = 4,
    parameter int INTERVAL_CYCLES = 100000,
    parameter int CNT_W           = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    input  wire logic             auto_en,
    output logic                  ro_en,
    output logic                  ro_cnt_clr,
    input  wire logic [CNT_W-1:0] ro_cnt,
    therm_seq_ctrl_if.master      tx,
    output logic [CNT_W-1:0]      sample,
    output logic                  sample_valid,
    output logic                  busy
);

    localparam int c_MAX_CYC = max_of4(SETTLE_CYCLES, GATE_CYCLES, HOLD_CYCLES, INTERVAL_CYCLES);
    localparam int c_TW      = (c_MAX_CYC <= 2) ? 1 : $clog2(c_MAX_CYC);

    localparam logic [c_TW-1:0] c_SETTLE_LAST   = c_TW'(SETTLE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_GATE_LAST     = c_TW'(GATE_CYCLES - 1);
    localparam logic [c_TW-1:0] c_HOLD_LAST     = c_TW'(HOLD_CYCLES - 1);
    localparam logic [c_TW-1:0] c_INTERVAL_LAST = c_TW'(INTERVAL_CYCLES - 1);

    if (CNT_W < 9 || CNT_W > 16) begin : g_cnt_w_check
        $error("therm_seq_ctrl: CNT_W must be in 9..16");
    end

    therm_seq_state_t r_state;
    therm_seq_state_t w_next;
    logic [c_TW-1:0]  r_cnt;
    logic             w_done;
    logic             w_load;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start || auto_en)         w_next = ST_SETTLE;
            ST_SETTLE:  if (r_cnt == c_SETTLE_LAST)   w_next = ST_GATE;
            ST_GATE:    if (r_cnt == c_GATE_LAST)     w_next = ST_HOLD;
            ST_HOLD:    if (r_cnt == c_HOLD_LAST)     w_next = ST_CAPTURE;
            ST_CAPTURE:                               w_next = ST_SEND;
            ST_SEND:    if (w_done)                   w_next = auto_en ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (!auto_en)                         w_next = ST_IDLE;
                else if (r_cnt == c_INTERVAL_LAST)    w_next = ST_SETTLE;
            end
            default:                                  w_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            ro_en        <= 1'b0;
            ro_cnt_clr   <= 1'b0;
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample       <= '0;
        end else begin
            r_state      <= w_next;
            r_cnt        <= (w_next != r_state) ? '0 : r_cnt + c_TW'(1);
            ro_en        <= (w_next == ST_SETTLE) || (w_next == ST_GATE);
            ro_cnt_clr   <= (w_next == ST_SETTLE);
            busy         <= (w_next != ST_IDLE);
            sample_valid <= (w_next == ST_CAPTURE);
            if (w_next == ST_CAPTURE) begin
                sample <= ro_cnt;
            end
        end
    end

    assign w_load = (r_state == ST_CAPTURE);

    therm_frame_tx u_frame_tx (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .cnt  (16'(sample)),
        .tx   (tx),
        .done (w_done)
    );

endmodule

`default_nettype wire

// File: tb/tb_therm_seq_ctrl.sv
// ============================================================================
//  Module  : tb_therm_seq_ctrl
//  Brief   : Directed self-checking bench for therm_seq_ctrl (16- and 12-bit).
//  Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_therm_seq_ctrl;

    localparam int S = 4;
    localparam int G = 10;
    localparam int H = 2;
    localparam int I = 100;
`ifdef THERM_SEQ_CHECKSUM_EN
    localparam int FLEN = 4;
`else
    localparam int FLEN = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0, auto_a = 1'b0, start_b = 1'b0, auto_b = 1'b0;
    logic [15:0] ro_cnt_a = 16'h1234;
    logic [11:0] ro_cnt_b = 12'hABC;
    logic        ro_en_a, clr_a, sv_a, busy_a;
    logic        ro_en_b, clr_b, sv_b, busy_b;
    logic [15:0] sample_a;
    logic [11:0] sample_b;

    therm_seq_ctrl_if bus_a ();
    therm_seq_ctrl_if bus_b ();

    always #5 clk = ~clk;

    therm_seq_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .HOLD_CYCLES(H),
                     .INTERVAL_CYCLES(I), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .auto_en(auto_a),
        .ro_en(ro_en_a), .ro_cnt_clr(clr_a), .ro_cnt(ro_cnt_a), .tx(bus_a),
        .sample(sample_a), .sample_valid(sv_a), .busy(busy_a));

    therm_seq_ctrl #(.SETTLE_CYCLES(S), .GATE_CYCLES(G), .HOLD_CYCLES(H),
                     .INTERVAL_CYCLES(I), .CNT_W(12)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .auto_en(auto_b),
        .ro_en(ro_en_b), .ro_cnt_clr(clr_b), .ro_cnt(ro_cnt_b), .tx(bus_b),
        .sample(sample_b), .sample_valid(sv_b), .busy(busy_b));

    // Edge-numbered transfer log and ro_en / sample_valid observers.
    int         cyc = 0;
    logic [7:0] q_a[$], q_b[$];
    int         xc_a[$];
    int         rise_a = 0, rise_cnt_a = 0, en_len_a = 0, sv_cnt_a = 0, sv_cyc_a = 0;
    logic       prev_en_a = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus_a.tx_valid && bus_a.tx_ready) begin
            q_a.push_back(bus_a.tx_data);
            xc_a.push_back(cyc);
        end
        if (bus_b.tx_valid && bus_b.tx_ready) q_b.push_back(bus_b.tx_data);
    end

    always @(negedge clk) begin
        if (ro_en_a && !prev_en_a) begin
            rise_a     = cyc;
            rise_cnt_a = rise_cnt_a + 1;
        end
        if (ro_en_a) en_len_a = en_len_a + 1;
        if (sv_a) begin
            sv_cnt_a = sv_cnt_a + 1;
            sv_cyc_a = cyc;
        end
        prev_en_a = ro_en_a;
    end

    int n_vec = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input bit use_b, input int base, input logic [15:0] cnt);
        logic [7:0] e[4];
        logic [7:0] got;
        e[0] = 8'hA5;
        e[1] = cnt[15:8];
        e[2] = cnt[7:0];
        e[3] = 8'hA5 + cnt[15:8] + cnt[7:0];
        for (int i = 0; i < FLEN; i++) begin
            got = 8'hxx;
            if (use_b && q_b.size() > base + i) got = q_b[base + i];
            if (!use_b && q_a.size() > base + i) got = q_a[base + i];
            chk($sformatf("%s byte%0d", tag, i), {24'd0, got}, {24'd0, e[i]});
        end
    endtask

    task automatic clear_a();
        @(posedge clk);
        #1;
        q_a.delete();
        xc_a.delete();
        rise_cnt_a = 0;
        en_len_a   = 0;
        sv_cnt_a   = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int t;
        int start_edge;
        int last_x;

        bus_a.tx_ready = 1'b1;
        bus_b.tx_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst ro_en",        {31'd0, ro_en_a},        32'd0);
        chk("rst ro_cnt_clr",   {31'd0, clr_a},          32'd0);
        chk("rst tx_valid",     {31'd0, bus_a.tx_valid}, 32'd0);
        chk("rst tx_data",      {24'd0, bus_a.tx_data},  32'd0);
        chk("rst sample",       {16'd0, sample_a},       32'd0);
        chk("rst sample_valid", {31'd0, sv_a},           32'd0);
        chk("rst busy",         {31'd0, busy_a},         32'd0);
        rst = 1'b0;

        // Single shot, count 0x1234
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_edge = cyc;
        chk("ss ro_en",  {31'd0, ro_en_a}, 32'd1);
        chk("ss busy",   {31'd0, busy_a},  32'd1);
        chk("ss clr",    {31'd0, clr_a},   32'd1);
        @(negedge clk);
        start_a = 1'b0;
        repeat (40) @(negedge clk);
        chk_frame("ss", 1'b0, 0, 16'h1234);
        chk("ss nbytes",   q_a.size(), FLEN);
        chk("ss ro_en len", en_len_a, S + G);
        chk("ss sv pulses", sv_cnt_a, 1);
        chk("ss sv edge",   sv_cyc_a, start_edge + S + G + H);
        chk("ss sample",    {16'd0, sample_a}, 32'h1234);
        chk("ss first xfer", (xc_a.size() > 0) ? xc_a[0] : -1, start_edge + S + G + H + 2);
        chk("ss last xfer",  (xc_a.size() >= FLEN) ? xc_a[FLEN-1] : -1, start_edge + S + G + H + 1 + FLEN);
        chk("ss busy end",  {31'd0, busy_a}, 32'd0);

        // Backpressure on the second byte
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        t = 0;
        while (!bus_a.tx_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("bp valid seen", {31'd0, bus_a.tx_valid}, 32'd1);
        @(negedge clk);
        bus_a.tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp hold data %0d", i),  {24'd0, bus_a.tx_data},  32'h12);
            chk($sformatf("bp hold valid %0d", i), {31'd0, bus_a.tx_valid}, 32'd1);
            @(negedge clk);
        end
        bus_a.tx_ready = 1'b1;
        repeat (20) @(negedge clk);
        chk_frame("bp", 1'b0, 0, 16'h1234);
        chk("bp nbytes", q_a.size(), FLEN);

        // Start pulse during SEND is dropped
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        t = 0;
        while (!bus_a.tx_valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (60) @(negedge clk);
        chk("sb nbytes", q_a.size(), FLEN);
        chk("sb rises",  rise_cnt_a, 1);
        chk("sb busy",   {31'd0, busy_a}, 32'd0);

        // Periodic mode, interval 100
        clear_a();
        @(negedge clk);
        auto_a = 1'b1;
        t = 0;
        while (q_a.size() < FLEN && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk("per frame1 n", q_a.size(), FLEN);
        last_x = (xc_a.size() >= FLEN) ? xc_a[FLEN-1] : 0;
        t = 0;
        while (rise_cnt_a < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("per gap", rise_a - last_x, I + 1);
        t = 0;
        while (q_a.size() < 2 * FLEN && t < 80) begin
            @(negedge clk);
            t++;
        end
        chk_frame("per2", 1'b0, FLEN, 16'h1234);
        repeat (10) @(negedge clk);
        chk("per wait busy", {31'd0, busy_a}, 32'd1);
        auto_a = 1'b0;
        @(posedge clk);
        #1;
        chk("per drop busy", {31'd0, busy_a}, 32'd0);
        repeat (150) @(negedge clk);
        chk("per rises", rise_cnt_a, 2);
        chk("per nbytes", q_a.size(), 2 * FLEN);

        // Asynchronous reset in GATE
        clear_a();
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("rg pre ro_en", {31'd0, ro_en_a}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rg ro_en",  {31'd0, ro_en_a}, 32'd0);
        chk("rg busy",   {31'd0, busy_a},  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_a();
        repeat (60) @(negedge clk);
        chk("rg nbytes", q_a.size(), 0);
        chk("rg busy after", {31'd0, busy_a}, 32'd0);

        // 12-bit counter instance, count 0xABC
        @(negedge clk);
        q_b.delete();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        repeat (40) @(negedge clk);
        chk_frame("w12", 1'b1, 0, 16'h0ABC);
        chk("w12 nbytes", q_b.size(), FLEN);
        chk("w12 sample", {20'd0, sample_b}, 32'hABC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
